ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer for the single-port 16K x 8 RAM.
//  Port 0 (button write path) and port 1 (sequential read/scan path) each
//  issue one-word read or write transactions through a req/ack handshake.
//  The block latches the winning request, drives the RAM address/data/wren,
//  waits out the RAM read latency, and returns read data.
//  Sits between the requesters and the RAM instance in the top level.
// PARAMETERS
//  ADDR_W  14  RAM address width
//  DATA_W  8   RAM data width
//  RD_LAT  2   cycles from mem_addr valid to mem_q valid (>=1)
// PORTS
//  clk       in   1       system clock; one clock domain
//  rst       in   1       reset, asynchronous, active-low
//  req0      in   1       port 0 request; hold until ack0 is seen
//  we0       in   1       port 0: 1=write, 0=read
//  addr0     in   ADDR_W  port 0 address
//  wdata0    in   DATA_W  port 0 write data
//  ack0      out  1       port 0 done; one-cycle pulse
//  req1,we1,addr1,wdata1,ack1  same as port 0, for port 1
//  rdata     out  DATA_W  read data; valid with the ack of a read
//  busy      out  1       1 when state != IDLE
//  mem_addr  out  ADDR_W  RAM address (registered)
//  mem_data  out  DATA_W  RAM write data (registered)
//  mem_wren  out  1       RAM write enable (registered)
//  mem_q     in   DATA_W  RAM read data
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state=IDLE; mem_addr, mem_data, mem_wren,
//    ack0, ack1 and rdata all 0; busy=0; last_grant=1, so port 0 wins the
//    first tie. mem_wren drops immediately, even during an active write.
//  - States: IDLE, WRITE, READ, DONE.
//  - IDLE, cycle T: if exactly one req is high, grant that port. If both
//    are high, grant the port != last_grant. On the grant edge:
//    latch addr->mem_addr and wdata->mem_data; set last_grant and
//    sel=granted port; cnt=0; next state is WRITE if we=1, else READ.
//  - WRITE, cycle T+1: mem_wren=1 for exactly this cycle. Next state DONE.
//  - READ, cycles T+1..T+RD_LAT: mem_wren=0; cnt counts up. At the edge
//    ending the last READ cycle: rdata<=mem_q, next state DONE.
//  - DONE: ack[sel]=1 for one cycle; no arbitration; next state IDLE.
//    Write ack is at T+2. Read ack is at T+RD_LAT+1.
//  - rdata holds its value until the next read completes. Writes do not
//    change rdata.
//  - Requester rule: drop req, or present a new transaction, the cycle after
//    ack is seen. Because of the DONE gap, a stale req is never double-granted.
//  - A req dropped before its grant is ignored. A req dropped after its grant
//    still completes, and its ack still pulses.
//  - A port that holds req continuously is re-granted in every IDLE. With
//    both ports requesting, grants strictly alternate. Worst-case wait is
//    one foreign transaction.
//  - Full range 0..2^ADDR_W-1 is valid. No wrap or alias logic.
//  - mem_addr and mem_data hold their values between transactions.
// TESTING
//  1 Assert rst=0 mid-WRITE -> mem_wren, ack0, ack1, rdata and busy = 0
//    at once; after release, first tie grants port 0.
//  2 Port0 writes 0x0005/0xA5 -> mem_wren=1 only at T+1 with
//    mem_addr=0x0005, mem_data=0xA5; ack0 at T+2; busy T+1..T+2.
//  3 Port1 reads 0x0005 (RAM model, RD_LAT=2) -> ack1 at T+3, rdata=0xA5;
//    mem_wren stays 0.
//  4 req0 and req1 held high from reset -> grant order 0,1,0,1; each ack
//    is a single-cycle pulse.
//  5 Write 0x3FFF=0xFF, write 0x0000=0x11, then read both -> 0xFF and 0x11.
//  6 req0 high for one cycle only, plus req1 asserted during DONE -> port 0
//    completes with one ack0; port 1 is granted only in the next IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin two-port sequencer for a single-port synchronous RAM: latches the
// winning one-word request, drives the registered RAM interface and returns read data.
module ram_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_wren_q, mem_wren_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              busy_q, busy_d;

   logic              gnt0_s;
   logic              gnt1_s;
   logic              win_we_s;
   logic [ADDR_W-1:0] win_addr_s;
   logic [DATA_W-1:0] win_data_s;

   // On a tie the port that did not win last time is served.
   assign gnt0_s     = req0 & (~req1 | last_grant_q);
   assign gnt1_s     = req1 & ~gnt0_s;
   assign win_we_s   = gnt1_s ? we1    : we0;
   assign win_addr_s = gnt1_s ? addr1  : addr0;
   assign win_data_s = gnt1_s ? wdata1 : wdata0;

   // Next-state logic; acks and write enable are set one cycle early so they come out registered.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_wren_d   = 1'b0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata_d      = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0_s || gnt1_s) begin
               sel_d        = gnt1_s;
               last_grant_d = gnt1_s;
               cnt_d        = {CNT_W{1'b0}};
               mem_addr_d   = win_addr_s;
               mem_data_d   = win_data_s;
               if (win_we_s) begin
                  state_d    = S_WRITE;
                  mem_wren_d = 1'b1;
               end else begin
                  state_d    = S_READ;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            state_d = S_DONE;
            ack0_d  = ~sel_q;
            ack1_d  = sel_q;
         end
         S_READ: begin
            if (cnt_q == CNT_LAST) begin
               rdata_d = mem_q;
               state_d = S_DONE;
               ack0_d  = ~sel_q;
               ack1_d  = sel_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sel_q        <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= {CNT_W{1'b0}};
         mem_addr_q   <= {ADDR_W{1'b0}};
         mem_data_q   <= {DATA_W{1'b0}};
         mem_wren_q   <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata_q      <= {DATA_W{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_wren_q   <= mem_wren_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata_q      <= rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata    = rdata_q;
   assign busy     = busy_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_wren = mem_wren_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed scenarios plus randomized two-port
// traffic checked against a transaction-level memory model.
module tb_ram_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;

   logic              clk;
   logic              rst;
   logic              req0, we0, ack0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              req1, we1, ack1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   typedef struct {
      bit         we;
      logic [7:0] rd;
      int         lo;
      int         hi;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   logic [7:0] ref_mem[int];
   int         wr_list0[$];
   int         wr_list1[$];
   int         vec;
   int         misc;
   int         cyc;
   bit         pa0;
   bit         pa1;

   logic [7:0] ram [0:16383];
   logic [7:0] q_pipe;

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   // Synchronous RAM: registered address, data one cycle later (RD_LAT = 2 seen from the arbiter).
   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      q_pipe <= ram[mem_addr];
   end
   assign mem_q = q_pipe;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      vec = vec + 1;
      if (act !== expv) begin
         misc = misc + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic drive_port(input int p, input bit r, input bit w,
                             input logic [13:0] a, input logic [7:0] d);
      if (p == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   // Reference: each transaction is applied to the model memory when issued.
   task automatic push_exp(input int p, input bit w, input logic [13:0] a,
                           input logic [7:0] d, input int lo, input int hi);
      exp_t e;
      e.we = w;
      e.lo = lo;
      e.hi = hi;
      if (w) begin
         ref_mem[int'(a)] = d;
         e.rd = 8'h00;
      end else begin
         e.rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
      end
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic check_ack(input int p);
      exp_t e;
      vec = vec + 1;
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
         misc = misc + 1;
         $display("FAIL ack%0d_unexpected: ack seen with nothing pending (cycle %0d)", p, cyc);
      end else begin
         e = (p == 0) ? q0.pop_front() : q1.pop_front();
         if (cyc < e.lo || cyc > e.hi) begin
            misc = misc + 1;
            $display("FAIL ack%0d_time: got cycle %0d expected %0d..%0d", p, cyc, e.lo, e.hi);
         end
         if (!e.we) chk($sformatf("rdata_port%0d", p), 32'(rdata), 32'(e.rd));
      end
   endtask

   // Monitor: pops the scoreboard on every ack and checks pulse shape.
   initial begin
      pa0 = 1'b0;
      pa1 = 1'b0;
      forever begin
         @(negedge clk);
         if (ack0) begin
            check_ack(0);
            chk("ack0_single_pulse", 32'(pa0), 32'd0);
            chk("ack_exclusive", 32'(ack1), 32'd0);
         end
         if (ack1) begin
            check_ack(1);
            chk("ack1_single_pulse", 32'(pa1), 32'd0);
         end
         pa0 = ack0;
         pa1 = ack1;
      end
   end

   task automatic wait_ack(input int p);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = (p == 0) ? ack0 : ack1;
      end
      if (!got) begin
         vec  = vec + 1;
         misc = misc + 1;
         $display("FAIL ack%0d_timeout: got no ack expected one within 40 cycles", p);
      end
   endtask

   task automatic do_txn(input int p, input bit w, input logic [13:0] a,
                         input logic [7:0] d, input int lo_off, input int hi_off);
      int t;
      t = cyc;
      drive_port(p, 1'b1, w, a, d);
      push_exp(p, w, a, d, t + lo_off, t + hi_off);
      wait_ack(p);
      @(posedge clk); #1;
      drive_port(p, 1'b0, w, a, d);
   endtask

   // Transaction from an idle arbiter with cycle-exact RAM interface checks.
   task automatic run_checked(input int p, input bit w, input logic [13:0] a,
                              input logic [7:0] d, input int lat);
      int t;
      t = cyc;
      drive_port(p, 1'b1, w, a, d);
      push_exp(p, w, a, d, t + lat, t + lat);
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         chk("busy", 32'(busy), 32'(k != 0));
         chk("mem_wren", 32'(mem_wren), 32'(w && k == 1));
         if (k == 1) begin
            chk("mem_addr", 32'(mem_addr), 32'(a));
            chk("mem_data", 32'(mem_data), 32'(d));
         end
      end
      @(posedge clk); #1;
      drive_port(p, 1'b0, w, a, d);
   endtask

   task automatic rand_port(input int p, input int n);
      bit         w;
      int         a;
      int         lat;
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         w = ($urandom_range(0, 1) == 1) || (p == 0 ? wr_list0.size() == 0 : wr_list1.size() == 0);
         if (w) begin
            a = int'($urandom_range(0, 8191)) * 2 + p;
            if (p == 0) wr_list0.push_back(a);
            else        wr_list1.push_back(a);
         end else if (p == 0) begin
            a = wr_list0[$urandom_range(0, wr_list0.size() - 1)];
         end else begin
            a = wr_list1[$urandom_range(0, wr_list1.size() - 1)];
         end
         d   = 8'($urandom_range(0, 255));
         lat = w ? 2 : RD_LAT + 1;
         do_txn(p, w, 14'(a), d, lat, lat + RD_LAT + 2);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      vec  = 0;
      misc = 0;
      rst  = 1'b0;
      drive_port(0, 1'b0, 1'b0, 14'h0000, 8'h00);
      drive_port(1, 1'b0, 1'b0, 14'h0000, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_wren", 32'(mem_wren), 32'd0);
      chk("reset_ack0", 32'(ack0), 32'd0);
      chk("reset_ack1", 32'(ack1), 32'd0);
      chk("reset_rdata", 32'(rdata), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_mem_data", 32'(mem_data), 32'd0);
      rst = 1'b1;

      run_checked(0, 1'b1, 14'h0005, 8'hA5, 2);
      run_checked(1, 1'b0, 14'h0005, 8'h00, RD_LAT + 1);
      run_checked(0, 1'b1, 14'h3FFF, 8'hFF, 2);
      run_checked(0, 1'b1, 14'h0000, 8'h11, 2);
      run_checked(1, 1'b0, 14'h3FFF, 8'h00, RD_LAT + 1);
      run_checked(1, 1'b0, 14'h0000, 8'h00, RD_LAT + 1);

      // Short port-0 request; port 1 shows up during DONE and waits for the next IDLE.
      t = cyc;
      drive_port(0, 1'b1, 1'b1, 14'h0010, 8'h77);
      push_exp(0, 1'b1, 14'h0010, 8'h77, t + 2, t + 2);
      @(posedge clk); #1;
      drive_port(0, 1'b0, 1'b0, 14'h0000, 8'h00);
      @(posedge clk); #1;
      drive_port(1, 1'b1, 1'b0, 14'h3FFF, 8'h00);
      push_exp(1, 1'b0, 14'h3FFF, 8'h00, t + 3 + RD_LAT + 1, t + 3 + RD_LAT + 1);
      wait_ack(1);
      @(posedge clk); #1;
      drive_port(1, 1'b0, 1'b0, 14'h0000, 8'h00);

      // Reset in the middle of a write, then both ports requesting from reset.
      drive_port(0, 1'b1, 1'b1, 14'h0123, 8'h3C);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wren_before_reset", 32'(mem_wren), 32'd1);
      rst = 1'b0;
      #1;
      chk("midwrite_rst_wren", 32'(mem_wren), 32'd0);
      chk("midwrite_rst_ack0", 32'(ack0), 32'd0);
      chk("midwrite_rst_ack1", 32'(ack1), 32'd0);
      chk("midwrite_rst_rdata", 32'(rdata), 32'd0);
      chk("midwrite_rst_busy", 32'(busy), 32'd0);
      chk("midwrite_rst_mem_addr", 32'(mem_addr), 32'd0);
      drive_port(1, 1'b1, 1'b1, 14'h0201, 8'hC3);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      fork
         begin
            do_txn(0, 1'b1, 14'h0100, 8'h5A, 2, 2);
            do_txn(0, 1'b1, 14'h0102, 8'h6B, 5, 5);
         end
         begin
            do_txn(1, 1'b1, 14'h0201, 8'hC3, 5, 5);
            do_txn(1, 1'b1, 14'h0203, 8'hD4, 5, 5);
         end
      join

      fork
         rand_port(0, 150);
         rand_port(1, 150);
      join

      repeat (6) @(posedge clk);
      chk("port0_queue_drained", 32'(q0.size()), 32'd0);
      chk("port1_queue_drained", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
      $finish;
   end

endmodule
